softmax_prenorm: RTL and testbench

- Max-subtraction normaliser placed directly upstream of the softmax stage.
- Accepts one logit vector of IN_LENGTH signed elements as a valid/ready stream, buffers it, and finds its maximum and argmax.
- Replays each element as the non-negative distance (max - x), saturated to OUT_BITS, so the exponential LUT downstream is indexed by exp(-d) and never overflows.
- Also publishes the vector argmax for classification.

---
 rtl/softmax_prenorm.sv | 122 ++++++++++++
 tb/tb_softmax_prenorm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/softmax_prenorm.sv
// Max-subtraction normaliser ahead of the softmax stage: buffers one logit vector,
// finds its max/argmax, then replays each element as saturated (max - x).
module softmax_prenorm #(
  parameter int BIT_REP   = 8,
  parameter int IN_LENGTH = 10,
  parameter int OUT_BITS  = 8,
  parameter int IDX_BITS  = $clog2(IN_LENGTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BIT_REP-1:0]  in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [OUT_BITS-1:0] out_data,
  output logic                       out_last,
  output logic signed [BIT_REP-1:0]  max_val,
  output logic        [IDX_BITS-1:0] max_idx,
  output logic                       err
);

  typedef enum logic {COLLECT, EMIT} state_t;

  localparam logic [IDX_BITS-1:0] LAST    = IDX_BITS'(IN_LENGTH - 1);
  localparam logic [BIT_REP:0]    SAT_MAX = (BIT_REP + 1)'((64'd1 << OUT_BITS) - 64'd1);

  state_t                     state;
  logic signed [BIT_REP-1:0]  mem [IN_LENGTH];
  logic        [IDX_BITS-1:0] wr_cnt;
  logic        [IDX_BITS-1:0] rd_cnt;
  logic        [IDX_BITS-1:0] rd_nxt;
  logic signed [BIT_REP-1:0]  run_max;
  logic        [IDX_BITS-1:0] run_idx;
  logic                       accept;
  logic                       final_in;
  logic                       take_new;
  logic signed [BIT_REP-1:0]  new_max;
  logic        [IDX_BITS-1:0] new_idx;

  // Distance at BIT_REP+1 bits is always non-negative because m is the vector max.
  function automatic logic [OUT_BITS-1:0] sat_dist(input logic signed [BIT_REP-1:0] m,
                                                   input logic signed [BIT_REP-1:0] x);
    logic [BIT_REP:0] d;
    d = {m[BIT_REP-1], m} - {x[BIT_REP-1], x};
    if (d > SAT_MAX) return '1;
    return d[OUT_BITS-1:0];
  endfunction

  always_comb begin
    accept   = in_valid && in_ready && (state == COLLECT);
    final_in = (wr_cnt == LAST);
    take_new = (wr_cnt == '0) || (in_data > run_max);
    new_max  = take_new ? in_data : run_max;
    new_idx  = take_new ? wr_cnt : run_idx;
    rd_nxt   = (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      max_val   <= '0;
      max_idx   <= '0;
      err       <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      run_max   <= '0;
      run_idx   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (in_last != final_in) err <= 1'b1;
            run_max <= new_max;
            run_idx <= new_idx;
            if (final_in) begin
              // mem[0] is already written (IN_LENGTH >= 2), so the first
              // distance can be formed from the final max in the same cycle.
              state     <= EMIT;
              wr_cnt    <= '0;
              in_ready  <= 1'b0;
              max_val   <= new_max;
              max_idx   <= new_idx;
              rd_cnt    <= '0;
              out_valid <= 1'b1;
              out_data  <= sat_dist(new_max, mem[0]);
              out_last  <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            if (rd_cnt == LAST) begin
              state     <= COLLECT;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rd_cnt    <= '0;
            end else begin
              rd_cnt   <= rd_nxt;
              out_data <= sat_dist(max_val, mem[rd_nxt]);
              out_last <= (rd_nxt == LAST);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_prenorm.sv
// Directed bench for softmax_prenorm: two instances (OUT_BITS 8 and 4) share one stimulus.
module tb_softmax_prenorm;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b1;

  logic              in_ready_a, out_valid_a, out_last_a, err_a;
  logic [7:0]        out_data_a;
  logic signed [7:0] max_val_a;
  logic [1:0]        max_idx_a;

  logic              in_ready_b, out_valid_b, out_last_b, err_b;
  logic [3:0]        out_data_b;
  logic signed [7:0] max_val_b;
  logic [1:0]        max_idx_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  softmax_prenorm #(.BIT_REP(8), .IN_LENGTH(4), .OUT_BITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a),
    .max_val(max_val_a), .max_idx(max_idx_a), .err(err_a)
  );

  softmax_prenorm #(.BIT_REP(8), .IN_LENGTH(4), .OUT_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b),
    .max_val(max_val_b), .max_idx(max_idx_b), .err(err_b)
  );

  typedef struct {
    int x[4];
    int lastpos;
    int ea[4];
    int eb[4];
    int mv;
    int mi;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic send(input int v, input int hold_next);
    for (int i = 0; i < 4; i++) begin
      int t;
      in_valid = 1'b1;
      in_data  = 8'(vecs[v].x[i]);
      in_last  = (i == vecs[v].lastpos);
      t = 0;
      while (!in_ready_a && t < 50) begin
        @(posedge clk); #1; t++;
      end
      chk("in_ready_wait", int'(in_ready_a), 1);
      if (i == 3) chk("out_valid_before_last_accept", int'(out_valid_a), 0);
      @(posedge clk); #1;
    end
    chk("latency_out_valid", int'(out_valid_a), 1);
    chk("emit_in_ready", int'(in_ready_a), 0);
    if (hold_next >= 0) begin
      in_data = 8'(vecs[hold_next].x[0]);
      in_last = 1'b0;
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic recv(input int v, input int ks, input int ke);
    for (int k = ks; k <= ke; k++) begin
      int t;
      t = 0;
      while (!out_valid_a && t < 20) begin
        @(posedge clk); #1; t++;
      end
      chk("out_valid", int'(out_valid_a), 1);
      chk("out_valid_b", int'(out_valid_b), 1);
      chk("out_data_a", int'(out_data_a), vecs[v].ea[k]);
      chk("out_data_b", int'(out_data_b), vecs[v].eb[k]);
      chk("out_last", int'(out_last_a), (k == 3) ? 1 : 0);
      chk("in_ready_emit", int'(in_ready_a), 0);
      chk("max_val", int'(max_val_a), vecs[v].mv);
      chk("max_idx", int'(max_idx_a), vecs[v].mi);
      chk("max_idx_b", int'(max_idx_b), vecs[v].mi);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0].x = '{10, -3, 25, 25};      vecs[0].lastpos = 3;
    vecs[0].ea = '{15, 28, 0, 0};       vecs[0].eb = '{15, 15, 0, 0};
    vecs[0].mv = 25;                    vecs[0].mi = 2;
    vecs[1].x = '{-128, 127, 120, 127}; vecs[1].lastpos = 3;
    vecs[1].ea = '{255, 0, 7, 0};       vecs[1].eb = '{15, 0, 7, 0};
    vecs[1].mv = 127;                   vecs[1].mi = 1;
    vecs[2].x = '{1, 2, 3, 4};          vecs[2].lastpos = 1;
    vecs[2].ea = '{3, 2, 1, 0};         vecs[2].eb = '{3, 2, 1, 0};
    vecs[2].mv = 4;                     vecs[2].mi = 3;
    vecs[3].x = '{1, 2, 3, 4};          vecs[3].lastpos = 3;
    vecs[3].ea = '{3, 2, 1, 0};         vecs[3].eb = '{3, 2, 1, 0};
    vecs[3].mv = 4;                     vecs[3].mi = 3;
    vecs[4].x = '{-5, -5, -7, 100};     vecs[4].lastpos = 3;
    vecs[4].ea = '{105, 105, 107, 0};   vecs[4].eb = '{15, 15, 15, 0};
    vecs[4].mv = 100;                   vecs[4].mi = 3;

    #12;
    chk("rst_in_ready", int'(in_ready_a), 1);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_data", int'(out_data_a), 0);
    chk("rst_out_last", int'(out_last_a), 0);
    chk("rst_max_val", int'(max_val_a), 0);
    chk("rst_max_idx", int'(max_idx_a), 0);
    chk("rst_err", int'(err_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 2; v++) begin
      send(v, -1);
      recv(v, 0, 3);
      chk("err_clean", int'(err_a), 0);
      chk("back_to_collect", int'(in_ready_a), 1);
      chk("idle_out_valid", int'(out_valid_a), 0);
    end

    // Backpressure on element 1 for three cycles.
    send(0, -1);
    recv(0, 0, 0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_valid", int'(out_valid_a), 1);
      chk("bp_data", int'(out_data_a), 28);
      chk("bp_last", int'(out_last_a), 0);
      chk("bp_in_ready", int'(in_ready_a), 0);
      chk("bp_max_val", int'(max_val_a), 25);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    recv(0, 1, 3);

    // Back-to-back with in_valid held high across EMIT.
    send(3, 4);
    recv(3, 0, 3);
    chk("b2b_in_ready", int'(in_ready_a), 1);
    send(4, -1);
    recv(4, 0, 3);

    // Early in_last: error is sticky, length still set by the counter.
    send(2, -1);
    chk("frame_err", int'(err_a), 1);
    chk("frame_err_b", int'(err_b), 1);
    recv(2, 0, 3);
    send(0, -1);
    recv(0, 0, 3);
    chk("frame_err_sticky", int'(err_a), 1);

    // Asynchronous reset during EMIT after element 1 handshake.
    send(0, -1);
    recv(0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid_a), 0);
    chk("arst_in_ready", int'(in_ready_a), 1);
    chk("arst_err", int'(err_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", int'(in_ready_a), 1);
    send(3, -1);
    recv(3, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
